// File: rtl/uart_pkg.sv
// Shared UART types, line levels and bit-timing helper.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Upstream word handshake into the UART transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick is high on the final clk of each bit period.
// clear restarts the period so every state entry gets a full bit.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick,
    output logic bit_tick_next_c
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;

    // tick is precomputed so it can be registered alongside the count
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
        bit_tick_next_c = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= bit_tick_next_c;
        end
    end

    assign bit_tick = tick_q;
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, stop bit(s); all outputs registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 115200,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave tx_if,
    output logic     tx,
    output logic     tx_busy,
    output logic     tx_done
);
    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned BIT_CNT_W    = $clog2(DATA_BITS) + 1;
    localparam int unsigned STOP_CNT_W   = $clog2(STOP_BITS) + 1;

    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 1");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
        $error("uart_tx: DATA_BITS must be 5..9");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1..2");
    end

    uart_state_e           state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [STOP_CNT_W-1:0] stop_cnt_q, stop_cnt_d;
    logic tx_q, tx_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic clear_c, bit_tick, bit_tick_next_c;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk             (clk),
        .reset           (reset),
        .clear           (clear_c),
        .bit_tick        (bit_tick),
        .bit_tick_next_c (bit_tick_next_c)
    );

    // Next state; outputs are derived from the next state so they line up with it
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        clear_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_if.tx_valid && ready_q) begin
                    state_d = S_START;
                    shift_d = DATA_BITS'(tx_if.tx_data);
                    clear_c = 1'b1;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    clear_c   = 1'b1;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        state_d    = S_STOP;
                        stop_cnt_d = '0;
                        clear_c    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (stop_cnt_q == STOP_CNT_W'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        clear_c = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + STOP_CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        tx_d = LINE_IDLE;
        case (state_d)
            S_START: tx_d = START_LVL;
            S_DATA:  tx_d = shift_d[0];
            S_STOP:  tx_d = STOP_LVL;
            default: tx_d = LINE_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_STOP) && (stop_cnt_d == STOP_CNT_W'(STOP_BITS - 1))
                  && bit_tick_next_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            tx_q       <= LINE_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign tx             = tx_q;
    assign tx_busy        = busy_q;
    assign tx_done        = done_q;
    assign tx_if.tx_ready = ready_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (4 clk/bit 8N1, 1 clk/bit 8N1, 4 clk/bit 7N2)
// checked cycle by cycle against a frame model built from the line format.
module tb_uart_tx;
    localparam int CPB_A = 460800 / 115200;
    localparam int CPB_B = 115200 / 115200;
    localparam int CPB_C = 460800 / 115200;

    logic clk;
    logic rst_a, rst_b, rst_c;
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;
    logic tx_c, busy_c, done_c;

    int checks;
    int errors;
    logic cap_tx    [0:127];
    logic cap_done  [0:127];
    logic cap_busy  [0:127];
    logic cap_ready [0:127];

    uart_tx_if #(.DATA_BITS(8)) ifa ();
    uart_tx_if #(.DATA_BITS(8)) ifb ();
    uart_tx_if #(.DATA_BITS(7)) ifc ();

    uart_tx #(.CLK_FREQ(460800), .BAUD_RATE(115200), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(rst_a), .tx_if(ifa), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a));
    uart_tx #(.CLK_FREQ(115200), .BAUD_RATE(115200), .DATA_BITS(8), .STOP_BITS(1)) dut_b (
        .clk(clk), .reset(rst_b), .tx_if(ifb), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b));
    uart_tx #(.CLK_FREQ(460800), .BAUD_RATE(115200), .DATA_BITS(7), .STOP_BITS(2)) dut_c (
        .clk(clk), .reset(rst_c), .tx_if(ifc), .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c));

    always #5 clk = ~clk;

    function automatic int nbits_of(input int d);
        return (d == 2) ? 7 : 8;
    endfunction
    function automatic int nstop_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction
    function automatic int cpb_of(input int d);
        return (d == 0) ? CPB_A : ((d == 1) ? CPB_B : CPB_C);
    endfunction

    // Expected line level i cycles into a frame: start, LSB-first data, then stop high
    function automatic logic exp_level(input int unsigned data, input int nbits,
                                       input int cpb, input int i);
        int k;
        k = i / cpb;
        if (k == 0) return 1'b0;
        if (k <= nbits) return ((data >> (k - 1)) & 32'd1) != 0;
        return 1'b1;
    endfunction

    function automatic logic cur_tx(input int d);
        return (d == 0) ? tx_a : ((d == 1) ? tx_b : tx_c);
    endfunction
    function automatic logic cur_done(input int d);
        return (d == 0) ? done_a : ((d == 1) ? done_b : done_c);
    endfunction
    function automatic logic cur_busy(input int d);
        return (d == 0) ? busy_a : ((d == 1) ? busy_b : busy_c);
    endfunction
    function automatic logic cur_ready(input int d);
        return (d == 0) ? ifa.tx_ready : ((d == 1) ? ifb.tx_ready : ifc.tx_ready);
    endfunction

    task automatic drive(input int d, input logic v, input int unsigned data);
        case (d)
            0:       begin ifa.tx_valid = v; ifa.tx_data = data[7:0]; end
            1:       begin ifb.tx_valid = v; ifb.tx_data = data[7:0]; end
            default: begin ifc.tx_valid = v; ifc.tx_data = data[6:0]; end
        endcase
    endtask

    task automatic drop_valid(input int d);
        case (d)
            0:       ifa.tx_valid = 1'b0;
            1:       ifb.tx_valid = 1'b0;
            default: ifc.tx_valid = 1'b0;
        endcase
    endtask

    task automatic wait_ready(input int d, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cur_ready(d) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Present a word for exactly the acceptance edge; returns in the first start-bit cycle
    task automatic send(input int d, input int unsigned data);
        drive(d, 1'b1, data);
        @(posedge clk); #1;
    endtask

    task automatic capture(input int d, input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (i == drop_at) drop_valid(d);
            cap_tx[i]    = cur_tx(d);
            cap_done[i]  = cur_done(d);
            cap_busy[i]  = cur_busy(d);
            cap_ready[i] = cur_ready(d);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx cyc=%0d got=%b exp=1", i, tx_a); end
            checks++; if (ifa.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready cyc=%0d got=%b exp=0", i, ifa.tx_ready); end
            checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy_a); end
            checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done cyc=%0d got=%b exp=0", i, done_a); end
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        drive(0, 1'b0, 0);
        @(posedge clk); #1;
        checks++; if (ifa.tx_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", ifa.tx_ready); end
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL release_tx got=%b exp=1", tx_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL release_busy got=%b exp=0", busy_a); end
    endtask

    task automatic test_frame(input int d, input int unsigned data, input string tag);
        int nb, cpb, len;
        bit ok;
        nb  = nbits_of(d);
        cpb = cpb_of(d);
        len = (1 + nb + nstop_of(d)) * cpb;
        wait_ready(d, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s ready_timeout got=0 exp=1", tag); end
        send(d, data);
        capture(d, len + 1, 0);
        for (int i = 0; i < len; i++) begin
            checks++; if (cap_tx[i] !== exp_level(data, nb, cpb, i)) begin errors++;
                $display("FAIL %s tx cyc=%0d got=%b exp=%b", tag, i, cap_tx[i], exp_level(data, nb, cpb, i)); end
            checks++; if (cap_done[i] !== (i == len - 1)) begin errors++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, i, cap_done[i], i == len - 1); end
            checks++; if (cap_busy[i] !== 1'b1) begin errors++;
                $display("FAIL %s busy cyc=%0d got=%b exp=1", tag, i, cap_busy[i]); end
        end
        checks++; if (cap_tx[len] !== 1'b1) begin errors++; $display("FAIL %s idle_tx got=%b exp=1", tag, cap_tx[len]); end
        checks++; if (cap_busy[len] !== 1'b0) begin errors++; $display("FAIL %s idle_busy got=%b exp=0", tag, cap_busy[len]); end
        checks++; if (cap_ready[len] !== 1'b1) begin errors++; $display("FAIL %s idle_ready got=%b exp=1", tag, cap_ready[len]); end
        checks++; if (cap_done[len] !== 1'b0) begin errors++; $display("FAIL %s idle_done got=%b exp=0", tag, cap_done[len]); end
    endtask

    task automatic test_back_to_back();
        int len, j;
        int unsigned w;
        bit ok, in_frame;
        logic e_tx;
        len = 10 * CPB_A;
        wait_ready(0, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b ready_timeout got=0 exp=1"); end
        send(0, 32'h00);
        drive(0, 1'b1, 32'hFF);
        capture(0, 2 * len + 2, len + 1);
        for (int i = 0; i < 2 * len + 2; i++) begin
            in_frame = (i < len) || ((i > len) && (i < 2 * len + 1));
            j = (i < len) ? i : i - len - 1;
            w = (i < len) ? 32'h00 : 32'hFF;
            e_tx = in_frame ? exp_level(w, 8, CPB_A, j) : 1'b1;
            checks++; if (cap_tx[i] !== e_tx) begin errors++;
                $display("FAIL b2b tx cyc=%0d got=%b exp=%b", i, cap_tx[i], e_tx); end
            checks++; if (cap_busy[i] !== in_frame) begin errors++;
                $display("FAIL b2b busy cyc=%0d got=%b exp=%b", i, cap_busy[i], in_frame); end
            checks++; if (cap_done[i] !== (in_frame && (j == len - 1))) begin errors++;
                $display("FAIL b2b done cyc=%0d got=%b exp=%b", i, cap_done[i], in_frame && (j == len - 1)); end
        end
        checks++; if (cap_ready[len] !== 1'b1) begin errors++; $display("FAIL b2b gap_ready got=%b exp=1", cap_ready[len]); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        wait_ready(0, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst ready_timeout got=0 exp=1"); end
        send(0, 32'h55);
        capture(0, 18, 0);
        for (int i = 0; i < 18; i++) begin
            checks++; if (cap_tx[i] !== exp_level(32'h55, 8, CPB_A, i)) begin errors++;
                $display("FAIL midrst pre_tx cyc=%0d got=%b exp=%b", i, cap_tx[i], exp_level(32'h55, 8, CPB_A, i)); end
        end
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL midrst tx cyc=%0d got=%b exp=1", i, tx_a); end
            checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL midrst done cyc=%0d got=%b exp=0", i, done_a); end
            checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst busy cyc=%0d got=%b exp=0", i, busy_a); end
        end
        rst_a = 1'b0;
        test_frame(0, 32'hC3, "after_rst_c3");
    endtask

    // Receiver model at 1 clk/bit: find start, read 8 LSB-first bits, expect stop and DONE there
    task automatic test_loopback();
        int unsigned words[6];
        int unsigned got;
        int s, dc;
        bit ok;
        words[0] = 32'h3C; words[1] = 32'h81; words[2] = 32'h7E;
        for (int n = 3; n < 6; n++) words[n] = $urandom_range(0, 255);
        for (int n = 0; n < 6; n++) begin
            wait_ready(1, 50, ok);
            checks++; if (!ok) begin errors++; $display("FAIL loop ready_timeout word=%0d got=0 exp=1", n); end
            send(1, words[n]);
            capture(1, 12, 0);
            s = -1;
            dc = 0;
            for (int i = 0; i < 12; i++) begin
                if ((s < 0) && (cap_tx[i] === 1'b0)) s = i;
                if (cap_done[i] === 1'b1) dc++;
            end
            checks++; if (s != 0) begin errors++; $display("FAIL loop start word=%0d got=%0d exp=0", n, s); end
            if (s < 0) s = 0;
            if (s > 2) s = 2;
            got = 0;
            for (int k = 0; k < 8; k++) if (cap_tx[s + 1 + k] === 1'b1) got += (32'd1 << k);
            checks++; if (got != words[n]) begin errors++; $display("FAIL loop data word=%0d got=%02h exp=%02h", n, got, words[n]); end
            checks++; if (cap_tx[s + 9] !== 1'b1) begin errors++; $display("FAIL loop stop word=%0d got=%b exp=1", n, cap_tx[s + 9]); end
            checks++; if (cap_done[s + 9] !== 1'b1) begin errors++; $display("FAIL loop done_pos word=%0d got=%b exp=1", n, cap_done[s + 9]); end
            checks++; if (dc != 1) begin errors++; $display("FAIL loop done_count word=%0d got=%0d exp=1", n, dc); end
        end
    endtask

    task automatic test_config();
        test_frame(2, 32'h41, "cfg_7n2_41");
        for (int n = 0; n < 3; n++) test_frame(2, $urandom_range(0, 127), "cfg_7n2_rand");
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) test_frame(0, $urandom_range(0, 255), "rand_8n1");
    endtask

    initial begin
        clk = 1'b0;
        checks = 0;
        errors = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        drive(0, 1'b1, 32'hA5);
        drive(1, 1'b0, 0);
        drive(2, 1'b0, 0);
        test_reset();
        test_frame(0, 32'hA5, "single_a5");
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        test_config();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
